regfile_dump_reader: RTL and testbench
======================================

// Module: regfile_dump_reader
// PURPOSE
//  Read-side initiator for the CPU register file. On a start pulse it walks a register range over one asynchronous
//  read port, emitting {addr, data} beats on a valid/ready stream. Feeds the debug/trace path.
//  Shares the register file's read port with a mux owned by the top level.
// PARAMETERS
//  REGISTER_DEPTH  32  number of registers in the file; any value 2..2^ADDR_WIDTH
//  ADDR_WIDTH       5  register address width
//  DATA_WIDTH      32  register word width
// PORTS
//  clk        in   1           clock; all state updates on posedge
//  reset      in   1           synchronous reset, active-high
//  start      in   1           one-cycle request; sampled only in IDLE
//  first_reg  in   ADDR_WIDTH  first register of the range; sampled with start
//  last_reg   in   ADDR_WIDTH  last register, inclusive; sampled with start
//  busy       out  1           scan in progress
//  done       out  1           one-cycle completion pulse
//  rd_reg     out  ADDR_WIDTH  register file read address
//  rd_data    in   DATA_WIDTH  register file read data, combinational from rd_reg
//  out_valid  out  1           output beat valid
//  out_ready  in   1           downstream accepts the beat
//  out_addr   out  ADDR_WIDTH  register number of the beat
//  out_data   out  DATA_WIDTH  register contents, or checksum
//  out_last   out  1           final beat of the scan
//  out_sum    out  1           beat carries the checksum; constant 0 without CHECKSUM_EN
// BEHAVIOUR
//  - Reset: state IDLE; busy, done, out_valid, out_last and out_sum = 0; rd_reg, out_addr and out_data = 0.
//  - States: IDLE -> SCAN -> [CSUM] -> DRAIN -> IDLE.
//  - Range reaches IDLE after the final handshake.
//  - IDLE + start at edge E0:
//    * addr counter <= first_reg; end <= last_reg; state SCAN; busy = 1 from cycle 1.
//    * A first_reg or last_reg value >= REGISTER_DEPTH is saturated to REGISTER_DEPTH-1.
//  - rd_reg is driven from the addr counter register.
//  - A load occurs when state is SCAN and the output slot is free (!out_valid || out_ready).
//    * On a load: out_data <= rd_data, out_addr <= addr, out_valid <= 1, and the counter advances.
//    * Earliest out_valid is in cycle 2. With out_ready held at 1, throughput is 1 beat per cycle.
//  - The captured word is the register value before any write committed at the same edge.
//  - Counter wrap: REGISTER_DEPTH-1 -> 0.
//    * Word count = ((last - first) mod REGISTER_DEPTH) + 1.
//    * first == last gives 1 beat; last < first wraps through 0.
//  - When the loaded addr == end:
//    * Without CHECKSUM_EN: out_last <= 1 and state DRAIN.
//    * With CHECKSUM_EN: state CSUM.
//  - A beat is held stable (data, addr, flags) while out_valid && !out_ready. No drops, no duplicates.
//  - DRAIN: on out_valid && out_ready && out_last, out_valid <= 0, done = 1 for one cycle, busy = 0 in that
//    same cycle, and state IDLE.
//  - start is ignored while busy, including the done cycle.
//  - reset mid-scan: next cycle IDLE, out_valid = 0, no done pulse, and the pending beat is discarded.
// CONFIGURATION
//  CHECKSUM_EN defined:
//    * A DATA_WIDTH wrapping sum of all dumped words accumulates on each load. It is cleared at start.
//    * CSUM loads one extra beat when the slot is free: out_data = sum, out_addr = all ones, out_sum = 1,
//      out_last = 1. Then DRAIN.
//  CHECKSUM_EN undefined: no accumulator, no CSUM state, out_sum tied 0.
// STRUCTURE
//  - regfile_pkg holds:
//    * state encodings (IDLE, SCAN, CSUM, DRAIN)
//    * default REGISTER_DEPTH, ADDR_WIDTH, DATA_WIDTH
//    * the checksum beat address constant
//  - Sub-module regdump_out_stage: a one-entry valid/ready output register with a load strobe.
//    It returns slot_free.
//  - The FSM, address counter and checksum stay in the top module.
// TESTING (register file preloaded r[i] = 0x1000 + i; out_ready = 1 unless stated)
//  1. first=0, last=31 -> 32 consecutive beats, addr 0..31, data 0x1000..0x101F.
//     out_last on addr 31; done one cycle after that handshake.
//  2. first=30, last=1 -> 4 beats, addr 30, 31, 0, 1, data 0x101E, 0x101F, 0x1000, 0x1001. out_last on addr 1.
//  3. first=last=7 -> single beat addr 7, data 0x1007, out_last=1; done next cycle.
//  4. Full scan, out_ready high 1 cycle in 3 -> 32 beats in order.
//     out_data and out_addr stable during stalls; done after beat 31.
//  5. start pulsed again while busy -> ignored.
//     reset asserted after the 5th handshake -> next cycle out_valid=0, busy=0, and no done ever pulses.
//  6. CHECKSUM_EN, first=0, last=3 -> 5 beats.
//     5th beat: out_data=0x4006, out_sum=1, out_last=1, out_addr=5'h1F.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file dump reader.
// CHECKSUM_EN (macro) enables the trailing checksum beat in regfile_dump_reader.
package regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_CSUM  = 2'd2,
    ST_DRAIN = 2'd3
  } dump_state_e;

  localparam int DEF_REGISTER_DEPTH = 32;
  localparam int DEF_ADDR_WIDTH     = 5;
  localparam int DEF_DATA_WIDTH     = 32;

  // Checksum beat address: all ones, sliced to ADDR_WIDTH by the user.
  localparam logic [31:0] CSUM_ADDR_ALL = 32'hFFFF_FFFF;

endpackage

// File: rtl/regdump_out_stage.sv
// One-entry valid/ready output register; load_i captures a beat when slot_free_o is high.
module regdump_out_stage #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  input  logic          last_i,
  input  logic          sum_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o,
  output logic          last_o,
  output logic          sum_o,
  output logic          slot_free_o
);

  logic          valid_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          last_q;
  logic          sum_q;

  // Beat register: a load overwrites only a free slot, so a stalled beat never moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      sum_q   <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
      data_q  <= data_i;
      last_q  <= last_i;
      sum_q   <= sum_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign slot_free_o = !valid_q || ready_i;
  assign valid_o     = valid_q;
  assign addr_o      = addr_q;
  assign data_o      = data_q;
  assign last_o      = last_q;
  assign sum_o       = sum_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a wrapping register range over an async read port and streams {addr, data} beats.
// Define CHECKSUM_EN to append a wrapping-sum beat (out_sum=1) after the last register.
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter int REGISTER_DEPTH = DEF_REGISTER_DEPTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_reg,
  input  logic [ADDR_WIDTH-1:0] last_reg,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_reg,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_sum
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(REGISTER_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR  = ADDR_WIDTH'(REGISTER_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] CSUM_ADDR = CSUM_ADDR_ALL[ADDR_WIDTH-1:0];

  function automatic logic [ADDR_WIDTH-1:0] sat_addr(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] r;
    if ({1'b0, a} >= DEPTH_W) begin
      r = MAX_ADDR;
    end else begin
      r = a;
    end
    return r;
  endfunction

  dump_state_e           state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] end_q;
  logic                  busy_q;
  logic                  done_q;
`ifdef CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;
`endif

  logic                  slot_free_s;
  logic                  load_s;
  logic                  at_end_s;
  logic [ADDR_WIDTH-1:0] ld_addr_s;
  logic [DATA_WIDTH-1:0] ld_data_s;
  logic                  ld_last_s;
  logic                  ld_sum_s;

  assign at_end_s = (addr_q == end_q);

  // Select what the output stage captures on a load.
  always_comb begin
    load_s    = 1'b0;
    ld_addr_s = addr_q;
    ld_data_s = rd_data;
    ld_last_s = 1'b0;
    ld_sum_s  = 1'b0;
    case (state_q)
      ST_SCAN: begin
        load_s = slot_free_s;
`ifdef CHECKSUM_EN
        ld_last_s = 1'b0;
`else
        ld_last_s = at_end_s;
`endif
      end
`ifdef CHECKSUM_EN
      ST_CSUM: begin
        load_s    = slot_free_s;
        ld_addr_s = CSUM_ADDR;
        ld_data_s = sum_q;
        ld_last_s = 1'b1;
        ld_sum_s  = 1'b1;
      end
`endif
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Control FSM; the done cycle is already IDLE, so start is also masked by done_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      end_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !done_q) begin
            addr_q  <= sat_addr(first_reg);
            end_q   <= sat_addr(last_reg);
            busy_q  <= 1'b1;
            state_q <= ST_SCAN;
`ifdef CHECKSUM_EN
            sum_q   <= '0;
`endif
          end
        end
        ST_SCAN: begin
          if (load_s) begin
            addr_q <= (addr_q == MAX_ADDR) ? '0 : addr_q + 1'b1;
`ifdef CHECKSUM_EN
            sum_q  <= sum_q + rd_data;
            if (at_end_s) state_q <= ST_CSUM;
`else
            if (at_end_s) state_q <= ST_DRAIN;
`endif
          end
        end
        ST_CSUM: begin
          if (load_s) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (out_valid && out_ready && out_last) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  regdump_out_stage #(
    .AW(ADDR_WIDTH),
    .DW(DATA_WIDTH)
  ) u_out (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_s),
    .addr_i     (ld_addr_s),
    .data_i     (ld_data_s),
    .last_i     (ld_last_s),
    .sum_i      (ld_sum_s),
    .ready_i    (out_ready),
    .valid_o    (out_valid),
    .addr_o     (out_addr),
    .data_o     (out_data),
    .last_o     (out_last),
    .sum_o      (out_sum),
    .slot_free_o(slot_free_s)
  );

  assign rd_reg = addr_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader; register file modelled as r[i] = 0x1000 + i.
// Adapts expected beat counts when CHECKSUM_EN is defined.
module tb_regfile_dump_reader;

`ifdef CHECKSUM_EN
  localparam int CSUM_ON = 1;
`else
  localparam int CSUM_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic        busy;
  logic        done;
  logic [4:0]  rd_reg;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_sum;

  int n_chk  = 0;
  int n_fail = 0;
  int k5;
  int done_seen;
  logic hs5;

  always #5 clk = ~clk;

  assign rd_data = 32'h0000_1000 + {27'd0, rd_reg};

  regfile_dump_reader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .first_reg(first_reg),
    .last_reg (last_reg),
    .busy     (busy),
    .done     (done),
    .rd_reg   (rd_reg),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr (out_addr),
    .out_data (out_data),
    .out_last (out_last),
    .out_sum  (out_sum)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one dump; per = out_ready period (1 = always ready).
  task automatic run_scan(input logic [4:0] f, input logic [4:0] l, input int words,
                          input int per, input string tag);
    int k, cyc, n;
    logic [4:0]  ea;
    logic [31:0] esum;
    logic        hs, fin;
    n    = words + CSUM_ON;
    esum = 32'd0;
    start = 1'b1; first_reg = f; last_reg = l; out_ready = 1'b0;
    tick();
    start = 1'b0;
    chk({tag, "_busy_c1"}, {31'd0, busy}, 32'd1);
    chk({tag, "_valid_c1"}, {31'd0, out_valid}, 32'd0);
    k = 0; cyc = 0; fin = 1'b0;
    while (!fin && cyc < 400) begin
      out_ready = ((cyc % per) == 0);
      hs = out_valid && out_ready;
      if (out_valid) begin
        if (k < words) begin
          ea = 5'(f + k);
          chk({tag, "_addr"}, {27'd0, out_addr}, {27'd0, ea});
          chk({tag, "_data"}, out_data, 32'h0000_1000 + {27'd0, ea});
          chk({tag, "_sumflag"}, {31'd0, out_sum}, 32'd0);
        end else begin
          chk({tag, "_csum_addr"}, {27'd0, out_addr}, 32'h1F);
          chk({tag, "_csum_data"}, out_data, esum);
          chk({tag, "_sumflag"}, {31'd0, out_sum}, 32'd1);
        end
        chk({tag, "_last"}, {31'd0, out_last}, (k == n - 1) ? 32'd1 : 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      end
      tick();
      cyc++;
      if (hs) begin
        if (k < words) esum = esum + 32'h0000_1000 + {27'd0, 5'(f + k)};
        k++;
        if (k == n) fin = 1'b1;
      end
    end
    chk({tag, "_beats"}, k, n);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_valid_done"}, {31'd0, out_valid}, 32'd0);
    // start during the done cycle must be ignored
    start = 1'b1; first_reg = 5'd3; last_reg = 5'd3;
    tick();
    start = 1'b0;
    chk({tag, "_done_clear"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_ign"}, {31'd0, busy}, 32'd0);
    tick();
    chk({tag, "_valid_ign"}, {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; first_reg = 5'd0; last_reg = 5'd0; out_ready = 1'b1;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_sum", {31'd0, out_sum}, 32'd0);
    chk("rst_rdreg", {27'd0, rd_reg}, 32'd0);
    chk("rst_addr", {27'd0, out_addr}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    reset = 1'b0;
    tick();

    run_scan(5'd0, 5'd31, 32, 1, "full");
    run_scan(5'd30, 5'd1, 4, 1, "wrap");
    run_scan(5'd7, 5'd7, 1, 1, "single");
    run_scan(5'd0, 5'd31, 32, 3, "stall");

    // start while busy is ignored; reset after the 5th handshake drops everything
    start = 1'b1; first_reg = 5'd0; last_reg = 5'd31; out_ready = 1'b1;
    tick();
    start = 1'b0;
    k5 = 0;
    for (int c = 0; c < 40 && k5 < 5; c++) begin
      if (c == 2) begin
        start = 1'b1; first_reg = 5'd20; last_reg = 5'd21;
      end else begin
        start = 1'b0;
      end
      hs5 = out_valid;
      if (out_valid) chk("busy_ign_addr", {27'd0, out_addr}, k5);
      tick();
      if (hs5) k5++;
    end
    start = 1'b0;
    chk("rst_mid_beats", k5, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) done_seen++;
      tick();
    end
    chk("rst_mid_nodone", done_seen, 0);
    chk("rst_mid_valid_end", {31'd0, out_valid}, 32'd0);

`ifdef CHECKSUM_EN
    // 0x1000+0x1001+0x1002+0x1003 = 0x4006 on the 5th beat
    start = 1'b1; first_reg = 5'd0; last_reg = 5'd3; out_ready = 1'b1;
    tick();
    start = 1'b0;
    k5 = 0;
    for (int c = 0; c < 20 && k5 < 5; c++) begin
      hs5 = out_valid;
      if (out_valid && k5 == 4) begin
        chk("csum_data", out_data, 32'h0000_4006);
        chk("csum_sum", {31'd0, out_sum}, 32'd1);
        chk("csum_last", {31'd0, out_last}, 32'd1);
        chk("csum_addr", {27'd0, out_addr}, 32'h1F);
      end
      tick();
      if (hs5) k5++;
    end
    chk("csum_beats", k5, 5);
    chk("csum_done", {31'd0, done}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
